// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the five-stage core.
// Arbitrates decode/execute stall requests, detects load-use hazards and
// sequences exception flushes (one-cycle flush pulse, then a front-end hold).
// Optional feature macro: PIPE_CTRL_PERF_EN adds two 32-bit performance
// counters (stall cycles, flush entries) to the port list.
module pipe_ctrl #(
  parameter int unsigned FLUSH_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq,
  input  logic        ex_stallreq,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_waddr,
  input  logic        id_reg0_re,
  input  logic        id_reg1_re,
  input  logic [4:0]  id_reg0_addr,
  input  logic [4:0]  id_reg1_addr,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Counter preload when leaving FLUSH; counting down to zero spans
  // exactly FLUSH_HOLD cycles in HOLD.
  localparam logic [3:0] HOLD_INIT =
    (FLUSH_HOLD == 32'd0) ? 4'd0 : 4'(FLUSH_HOLD - 32'd1);

  // Stall vector encodings (bit0 pc .. bit5 wb).
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_FRONT = 6'b000011;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_EX    = 6'b001111;
  localparam logic [5:0] STALL_ALL   = 6'b111111;

  state_t      state;
  state_t      next_state;
  logic [3:0]  hold_cnt;
  logic [3:0]  next_hold_cnt;
  logic        next_flush;
  logic [31:0] next_pc;
  logic        lu;
  logic        rd0_hit;
  logic        rd1_hit;

  // Load-use hazard: a load in execute writes a nonzero register that decode reads.
  always_comb begin
    rd0_hit = id_reg0_re && (id_reg0_addr == ex_waddr);
    rd1_hit = id_reg1_re && (id_reg1_addr == ex_waddr);
    lu      = ex_is_load && (ex_waddr != 5'd0) && (rd0_hit || rd1_hit);
  end

  // Stall arbitration: exception freezes all, then flush/hold, then requests.
  always_comb begin
    stall_o = STALL_NONE;
    if (rst) begin
      stall_o = STALL_NONE;
    end else if (excp_req) begin
      stall_o = STALL_ALL;
    end else begin
      case (state)
        FLUSH: stall_o = STALL_NONE;
        HOLD:  stall_o = STALL_FRONT;
        RUN: begin
          if (ex_stallreq) begin
            stall_o = STALL_EX;
          end else if (id_stallreq || lu) begin
            stall_o = STALL_ID;
          end else begin
            stall_o = STALL_NONE;
          end
        end
        default: stall_o = STALL_NONE;
      endcase
    end
  end

  // Next-state logic for the flush sequencer and its registered outputs.
  always_comb begin
    next_state    = state;
    next_hold_cnt = hold_cnt;
    next_flush    = 1'b0;
    next_pc       = new_pc_o;
    if (excp_req) begin
      // A new request restarts the sequence from any state.
      next_state    = FLUSH;
      next_hold_cnt = 4'd0;
      next_flush    = 1'b1;
      next_pc       = excp_pc;
    end else begin
      case (state)
        RUN: begin
          next_state = RUN;
        end
        FLUSH: begin
          if (FLUSH_HOLD == 32'd0) begin
            next_state = RUN;
          end else begin
            next_state    = HOLD;
            next_hold_cnt = HOLD_INIT;
          end
        end
        HOLD: begin
          if (hold_cnt == 4'd0) begin
            next_state = RUN;
          end else begin
            next_hold_cnt = hold_cnt - 4'd1;
          end
        end
        default: begin
          next_state    = RUN;
          next_hold_cnt = 4'd0;
        end
      endcase
    end
  end

  // Sequencer state, hold counter and registered flush/redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      hold_cnt <= 4'd0;
      flush_o  <= 1'b0;
      new_pc_o <= 32'd0;
    end else begin
      state    <= next_state;
      hold_cnt <= next_hold_cnt;
      flush_o  <= next_flush;
      new_pc_o <= next_pc;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic flush_entry;

  // A flush entry is counted only when arriving from RUN or HOLD, not on a
  // request that extends an ongoing FLUSH.
  always_comb begin
    flush_entry = excp_req && ((state == RUN) || (state == HOLD));
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= 32'd0;
      flush_count_o  <= 32'd0;
    end else begin
      if (stall_o != STALL_NONE) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end else begin
        stall_cycles_o <= stall_cycles_o;
      end
      if (flush_entry) begin
        flush_count_o <= flush_count_o + 32'd1;
      end else begin
        flush_count_o <= flush_count_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
// Honors PIPE_CTRL_PERF_EN to also check the performance counters.
module tb_pipe_ctrl;

  localparam int unsigned FH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stallreq;
  logic        ex_stallreq;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic        id_reg0_re;
  logic        id_reg1_re;
  logic [4:0]  id_reg0_addr;
  logic [4:0]  id_reg1_addr;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: "in flush cycle" flag, remaining hold cycles, redirect PC, counters.
  logic        m_in_flush  = 1'b0;
  int          m_hold_left = 0;
  logic [31:0] m_pc        = 32'd0;
  logic [31:0] m_stall_cnt = 32'd0;
  logic [31:0] m_flush_cnt = 32'd0;

  pipe_ctrl #(.FLUSH_HOLD(FH)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_stallreq  (id_stallreq),
    .ex_stallreq  (ex_stallreq),
    .ex_is_load   (ex_is_load),
    .ex_waddr     (ex_waddr),
    .id_reg0_re   (id_reg0_re),
    .id_reg1_re   (id_reg1_re),
    .id_reg0_addr (id_reg0_addr),
    .id_reg1_addr (id_reg1_addr),
    .excp_req     (excp_req),
    .excp_pc      (excp_pc),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .new_pc_o     (new_pc_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic model_hazard();
    logic reads_dest;
    reads_dest = (id_reg0_re && id_reg0_addr == ex_waddr) ||
                 (id_reg1_re && id_reg1_addr == ex_waddr);
    return ex_is_load && (ex_waddr != 5'd0) && reads_dest;
  endfunction

  function automatic logic [5:0] model_stall();
    if (rst)                            return 6'b000000;
    if (excp_req)                       return 6'b111111;
    if (m_in_flush)                     return 6'b000000;
    if (m_hold_left > 0)                return 6'b000011;
    if (ex_stallreq)                    return 6'b001111;
    if (id_stallreq || model_hazard())  return 6'b000111;
    return 6'b000000;
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_in_flush  = 1'b0;
      m_hold_left = 0;
      m_pc        = 32'd0;
      m_stall_cnt = 32'd0;
      m_flush_cnt = 32'd0;
    end else begin
      if (model_stall() != 6'b000000) m_stall_cnt = m_stall_cnt + 32'd1;
      if (excp_req) begin
        if (!m_in_flush) m_flush_cnt = m_flush_cnt + 32'd1;
        m_in_flush  = 1'b1;
        m_hold_left = 0;
        m_pc        = excp_pc;
      end else if (m_in_flush) begin
        m_in_flush  = 1'b0;
        m_hold_left = int'(FH);
      end else if (m_hold_left > 0) begin
        m_hold_left = m_hold_left - 1;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    id_stallreq  = 1'b0;
    ex_stallreq  = 1'b0;
    ex_is_load   = 1'b0;
    ex_waddr     = 5'd0;
    id_reg0_re   = 1'b0;
    id_reg1_re   = 1'b0;
    id_reg0_addr = 5'd0;
    id_reg1_addr = 5'd0;
    excp_req     = 1'b0;
    excp_pc      = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_stallreq = 1'b1; ex_stallreq = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd3;
    id_reg0_re = 1'b1; id_reg1_re = 1'b1; id_reg0_addr = 5'd3; id_reg1_addr = 5'd3;
    excp_req = 1'b1; excp_pc = 32'hDEAD_BEEF;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", stall_o); end
    n_checks++;
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_o); end
    n_checks++;
    if (new_pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_new_pc: got %h want 0", new_pc_o); end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (stall_cycles_o !== 32'd0 || flush_count_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles_o, flush_count_o);
    end
`endif
    rst = 1'b0;
    set_idle();
    step();
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL post_reset_stall: got %b want 000000", stall_o); end
    n_checks++;
    if (flush_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_flush: got %b want 0", flush_o); end
    step();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_is_load = 1'b1; ex_waddr = 5'd5; id_reg1_re = 1'b1; id_reg1_addr = 5'd5;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000111) begin n_fail++; $display("FAIL lu_port1: got %b want 000111", stall_o); end
    step();
    ex_waddr = 5'd0; id_reg1_addr = 5'd0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL lu_x0: got %b want 000000", stall_o); end
    step();
    ex_waddr = 5'd9; id_reg1_re = 1'b0; id_reg0_re = 1'b1; id_reg0_addr = 5'd9;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000111) begin n_fail++; $display("FAIL lu_port0: got %b want 000111", stall_o); end
    step();
    id_reg0_re = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL lu_port_disabled: got %b want 000000", stall_o); end
    step();
    id_reg0_re = 1'b1; ex_is_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL lu_not_load: got %b want 000000", stall_o); end
    step();
    set_idle();
  endtask

  task automatic test_priority();
    set_idle();
    id_stallreq = 1'b1; ex_stallreq = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b001111) begin n_fail++; $display("FAIL prio_ex_over_id: got %b want 001111", stall_o); end
    excp_req = 1'b1; excp_pc = 32'h0000_0AA0;
    #1;
    n_checks++;
    if (stall_o !== 6'b111111) begin n_fail++; $display("FAIL prio_excp: got %b want 111111", stall_o); end
    excp_req = 1'b0;
    #1;
    step();
    ex_stallreq = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000111) begin n_fail++; $display("FAIL prio_id_only: got %b want 000111", stall_o); end
    step();
    set_idle();
  endtask

  task automatic test_flush_seq();
    logic [31:0] base_stall;
    logic [31:0] base_flush;
    set_idle();
    base_stall = m_stall_cnt;
    base_flush = m_flush_cnt;
    excp_req = 1'b1; excp_pc = 32'h0000_0100;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b111111) begin n_fail++; $display("FAIL flush_n_stall: got %b want 111111", stall_o); end
    step();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h0000_0100 || stall_o !== 6'b000000) begin
      n_fail++; $display("FAIL flush_n1: got flush=%b pc=%h stall=%b want 1/00000100/000000", flush_o, new_pc_o, stall_o);
    end
    step();
    for (int i = 0; i < int'(FH); i++) begin
      @(negedge clk);
      n_checks++;
      if (stall_o !== 6'b000011 || flush_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_hold%0d: got stall=%b flush=%b want 000011/0", i, stall_o, flush_o);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000 || new_pc_o !== 32'h0000_0100) begin
      n_fail++; $display("FAIL flush_done: got stall=%b pc=%h want 000000/00000100", stall_o, new_pc_o);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (flush_count_o !== base_flush + 32'd1 || stall_cycles_o !== base_stall + 32'd3) begin
      n_fail++; $display("FAIL flush_perf: got flushes=%0d stalls=%0d want %0d/%0d",
                         flush_count_o, stall_cycles_o, base_flush + 32'd1, base_stall + 32'd3);
    end
`endif
    step();
  endtask

  task automatic test_rehold();
    logic [31:0] base_flush;
    set_idle();
    base_flush = m_flush_cnt;
    excp_req = 1'b1; excp_pc = 32'h0000_0100;
    step();
    set_idle();
    step();
    excp_req = 1'b1; excp_pc = 32'h0000_0200;
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b111111) begin n_fail++; $display("FAIL rehold_excp_stall: got %b want 111111", stall_o); end
    step();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h0000_0200) begin
      n_fail++; $display("FAIL rehold_flush: got flush=%b pc=%h want 1/00000200", flush_o, new_pc_o);
    end
    step();
    for (int i = 0; i < int'(FH); i++) begin
      @(negedge clk);
      n_checks++;
      if (stall_o !== 6'b000011) begin n_fail++; $display("FAIL rehold_hold%0d: got %b want 000011", i, stall_o); end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (stall_o !== 6'b000000) begin n_fail++; $display("FAIL rehold_done: got %b want 000000", stall_o); end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (flush_count_o !== base_flush + 32'd2) begin
      n_fail++; $display("FAIL rehold_perf: got %0d want %0d", flush_count_o, base_flush + 32'd2);
    end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0000_1000; pcs[1] = 32'h0000_2004; pcs[2] = 32'h0000_3008;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      excp_req = 1'b1; excp_pc = pcs[i];
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (flush_o !== 1'b1 || new_pc_o !== pcs[i-1] || stall_o !== 6'b111111) begin
          n_fail++; $display("FAIL b2b_cycle%0d: got flush=%b pc=%h stall=%b want 1/%h/111111",
                             i, flush_o, new_pc_o, stall_o, pcs[i-1]);
        end
      end
      step();
    end
    set_idle();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b1 || new_pc_o !== pcs[2] || stall_o !== 6'b000000) begin
      n_fail++; $display("FAIL b2b_last: got flush=%b pc=%h stall=%b want 1/%h/000000", flush_o, new_pc_o, stall_o, pcs[2]);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (flush_o !== 1'b0 || new_pc_o !== pcs[2] || stall_o !== 6'b000011) begin
      n_fail++; $display("FAIL b2b_hold: got flush=%b pc=%h stall=%b want 0/%h/000011", flush_o, new_pc_o, stall_o, pcs[2]);
    end
    for (int i = 0; i < int'(FH) + 1; i++) step();
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_stallreq  = ($urandom_range(0, 5) == 0);
      ex_stallreq  = ($urandom_range(0, 7) == 0);
      ex_is_load   = ($urandom_range(0, 1) == 0);
      ex_waddr     = 5'($urandom_range(0, 3));
      id_reg0_re   = ($urandom_range(0, 1) == 0);
      id_reg1_re   = ($urandom_range(0, 1) == 0);
      id_reg0_addr = 5'($urandom_range(0, 3));
      id_reg1_addr = 5'($urandom_range(0, 3));
      excp_req     = ($urandom_range(0, 11) == 0);
      excp_pc      = $urandom();
      @(negedge clk);
      n_checks++;
      if (stall_o !== model_stall() || flush_o !== m_in_flush || new_pc_o !== m_pc) begin
        n_fail++; $display("FAIL random_c%0d: got stall=%b flush=%b pc=%h want %b/%b/%h",
                           c, stall_o, flush_o, new_pc_o, model_stall(), m_in_flush, m_pc);
      end
`ifdef PIPE_CTRL_PERF_EN
      n_checks++;
      if (stall_cycles_o !== m_stall_cnt || flush_count_o !== m_flush_cnt) begin
        n_fail++; $display("FAIL random_perf_c%0d: got %0d/%0d want %0d/%0d",
                           c, stall_cycles_o, flush_count_o, m_stall_cnt, m_flush_cnt);
      end
`endif
      step();
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_priority();
    test_flush_seq();
    test_rehold();
    test_back_to_back();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage core. It arbitrates stall requests from decode and execute, and detects load-use hazards from decode's register read ports against the load in execute. It also sequences exception flushes: a one-cycle flush pulse with a redirect PC, followed by a fixed refetch hold. Its outputs drive the stall inputs of every pipeline register (pc, if/id, id/ex, ex/mem, mem/wb) and the redirect input of the PC register.

## Interface
Parameters:
- FLUSH_HOLD, default 2: cycles the front end (pc, if) is held after the flush pulse; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- id_stallreq  in  1  decode requests a stall
- ex_stallreq  in  1  execute requests a stall (multi-cycle op)
- ex_is_load  in  1  instruction in execute is a load
- ex_waddr  in  5  destination register of the instruction in execute
- id_reg0_re, id_reg1_re  in  1 each  decode read-port enables
- id_reg0_addr, id_reg1_addr  in  5 each  decode read-port addresses
- excp_req  in  1  exception/redirect request, level-sampled each cycle
- excp_pc  in  32  redirect target, valid with excp_req
- stall_o  out  6  stall vector, bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
- flush_o  out  1  flush all pipeline registers (registered)
- new_pc_o  out  32  redirect PC, valid while flush_o=1 (registered)
- stall_cycles_o  out  32  performance counter (PIPE_CTRL_PERF_EN only)
- flush_count_o  out  32  performance counter (PIPE_CTRL_PERF_EN only)

## Operation
- FSM states: RUN, FLUSH, HOLD. hold_cnt is a 4-bit down-counter.
- Reset (rst=1 at clock edge):
  - state=RUN, hold_cnt=0, flush_o=0, new_pc_o=0, counters=0.
  - While rst is high, stall_o is forced to 0 combinationally.
- Load-use hazard (lu) is asserted when all of these hold:
  - ex_is_load=1 and ex_waddr≠0;
  - (id_reg0_re and id_reg0_addr==ex_waddr) or (id_reg1_re and id_reg1_addr==ex_waddr).
- stall_o is combinational from state and inputs. Priority, highest first:
  1. excp_req=1 (any state): stall_o=6'b111111. Freezes everything so nothing younger commits.
  2. state=FLUSH: stall_o=6'b000000.
  3. state=HOLD: stall_o=6'b000011.
  4. ex_stallreq: stall_o=6'b001111.
  5. id_stallreq or lu: stall_o=6'b000111.
  6. Otherwise stall_o=6'b000000.
- Transitions:
  - Any state with excp_req=1: go to FLUSH; latch new_pc_o←excp_pc; flush_o←1. A request in FLUSH or HOLD restarts the sequence with the new PC.
  - FLUSH, excp_req=0:
    - FLUSH_HOLD=0: go to RUN.
    - Otherwise: go to HOLD with hold_cnt←FLUSH_HOLD-1.
    - flush_o←0.
  - HOLD: decrement hold_cnt each cycle; at hold_cnt=0, go to RUN.
- new_pc_o keeps its last value outside FLUSH.

## Timing
- excp_req sampled high at edge N: flush_o=1 and new_pc_o valid during cycle N+1 only (one cycle, unless excp_req is still high).
- Front-end hold occupies cycles N+2 .. N+1+FLUSH_HOLD. stall_o returns to normal arbitration in cycle N+2+FLUSH_HOLD.
- Stall and hazard requests take effect in the same cycle; latency is 0.
- excp_req held high for k cycles: flush_o is high for k cycles, and new_pc_o tracks the last sampled excp_pc.
- ex_waddr=0 never produces lu.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles_o increments on every cycle with stall_o≠0 and rst=0.
  - flush_count_o increments on every RUN→FLUSH or HOLD→FLUSH entry.
  - Both counters wrap modulo 2^32 and are cleared by rst.
- PIPE_CTRL_PERF_EN undefined: both counters are absent from the port list and no counter logic is built.

## Test plan
- Reset: hold rst=1 for 2 cycles with all requests high -> stall_o=0, flush_o=0, new_pc_o=0; after release with all inputs 0 -> stall_o=0.
- Load-use: ex_is_load=1, ex_waddr=5, id_reg1_re=1, id_reg1_addr=5 -> stall_o=6'b000111. Repeat with ex_waddr=0 -> stall_o=0.
- Priority: id_stallreq=1 and ex_stallreq=1 together -> stall_o=6'b001111. Add excp_req=1 -> 6'b111111.
- Flush sequence, FLUSH_HOLD=2: excp_req pulse with excp_pc=32'h0000_0100 at edge N ->
  - cycle N: stall_o=6'b111111;
  - cycle N+1: flush_o=1, new_pc_o=32'h100, stall_o=0;
  - cycles N+2, N+3: stall_o=6'b000011;
  - cycle N+4: stall_o=0 with idle inputs.
- Re-exception during HOLD: second excp_req with excp_pc=32'h200 one cycle into HOLD -> flush_o=1 again with new_pc_o=32'h200, then a full 2-cycle hold.
- PIPE_CTRL_PERF_EN: the flush-sequence test above -> flush_count_o=1 and stall_cycles_o=3 afterwards.
